// File: rtl/ft2232h_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ft2232h_cmd_decoder
// Brief    : FT2232H sync-FIFO read handshake plus 5-byte framed command parser
//            (AA, CMD, ADDR, DATA, CSUM) driving an LED and a control bank.
// Revision : 1.0  initial release
// ============================================================================
module ft2232h_cmd_decoder #(
    parameter int         NUM_REGS    = 4,
    parameter int         REG_AW      = 2,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] PREAMBLE    = 8'hAA,
    parameter logic [7:0] CMD_SETLED  = 8'h01,
    parameter logic [7:0] CMD_WRREG   = 8'h02,
    parameter logic [7:0] CMD_CLRALL  = 8'h03
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rxf_i,
    input  logic [7:0]            data_i,
    input  logic                  hold_i,
    output logic                  oe_o,
    output logic                  rd_o,
    output logic [7:0]            led_o,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic [7:0]            err_cnt_o
);

    localparam logic [1:0] c_RD_IDLE = 2'd0;
    localparam logic [1:0] c_RD_OE   = 2'd1;
    localparam logic [1:0] c_RD_READ = 2'd2;

    localparam logic [2:0] c_P_PRE  = 3'd0;
    localparam logic [2:0] c_P_CMD  = 3'd1;
    localparam logic [2:0] c_P_ADDR = 3'd2;
    localparam logic [2:0] c_P_DATA = 3'd3;
    localparam logic [2:0] c_P_CSUM = 3'd4;

    localparam int                c_TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);
    localparam logic [7:0]        c_NREGS8  = 8'(NUM_REGS);

    logic [1:0]        r_rd_state, w_rd_state_nxt;
    logic              r_oe, r_rd, w_oe_nxt, w_rd_nxt;
    logic [2:0]        r_p_state, w_p_state_nxt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_cmd, r_addr, r_data;
    logic [7:0]        r_led, r_err_cnt;
    logic [7:0]        r_regs [NUM_REGS];
    logic              r_ok, r_err;
    logic              w_accept, w_timeout, w_eval, w_csum_ok, w_cmd_ok;
    logic              w_good, w_bad;

    // ---------------- read handshake FSM ----------------
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_oe_nxt       = 1'b1;
        w_rd_nxt       = 1'b1;
        case (r_rd_state)
            c_RD_IDLE: begin
                if (!rxf_i && !hold_i) begin
                    w_rd_state_nxt = c_RD_OE;
                    w_oe_nxt       = 1'b0;
                end
            end
            c_RD_OE: begin
                w_rd_state_nxt = c_RD_READ;
                w_oe_nxt       = 1'b0;
                w_rd_nxt       = 1'b0;
            end
            c_RD_READ: begin
                if (rxf_i || hold_i) begin
                    w_rd_state_nxt = c_RD_IDLE;
                end else begin
                    w_oe_nxt = 1'b0;
                    w_rd_nxt = 1'b0;
                end
            end
            default: w_rd_state_nxt = c_RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rd_state <= c_RD_IDLE;
            r_oe       <= 1'b1;
            r_rd       <= 1'b1;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_oe       <= w_oe_nxt;
            r_rd       <= w_rd_nxt;
        end
    end

    // A byte on the edge where RXF# rises is left in the chip.
    assign w_accept = !r_rd && !rxf_i;

    // ---------------- frame parser FSM ----------------
    always_comb begin
        w_p_state_nxt = r_p_state;
        w_timeout     = 1'b0;
        if (w_accept) begin
            case (r_p_state)
                c_P_PRE:  w_p_state_nxt = (data_i == PREAMBLE) ? c_P_CMD : c_P_PRE;
                c_P_CMD:  w_p_state_nxt = c_P_ADDR;
                c_P_ADDR: w_p_state_nxt = c_P_DATA;
                c_P_DATA: w_p_state_nxt = c_P_CSUM;
                default:  w_p_state_nxt = c_P_PRE;
            endcase
        end else if (r_p_state != c_P_PRE && r_to_cnt == c_TO_LAST) begin
            w_timeout     = 1'b1;
            w_p_state_nxt = c_P_PRE;
        end
    end

    assign w_eval    = w_accept && (r_p_state == c_P_CSUM);
    assign w_csum_ok = (data_i == (r_cmd ^ r_addr ^ r_data));
    assign w_cmd_ok  = (r_cmd == CMD_SETLED) || (r_cmd == CMD_CLRALL) ||
                       ((r_cmd == CMD_WRREG) && (r_addr < c_NREGS8));
    assign w_good    = w_eval && w_csum_ok && w_cmd_ok;
    assign w_bad     = (w_eval && !(w_csum_ok && w_cmd_ok)) || w_timeout;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_p_state <= c_P_PRE;
            r_to_cnt  <= '0;
            r_cmd     <= 8'h00;
            r_addr    <= 8'h00;
            r_data    <= 8'h00;
        end else begin
            r_p_state <= w_p_state_nxt;
            if (w_accept || w_timeout || r_p_state == c_P_PRE) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end
            if (w_accept) begin
                if (r_p_state == c_P_CMD)  r_cmd  <= data_i;
                if (r_p_state == c_P_ADDR) r_addr <= data_i;
                if (r_p_state == c_P_DATA) r_data <= data_i;
            end
        end
    end

    // ---------------- command execution ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_led     <= 8'h00;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'h00;
        end else begin
            r_ok  <= w_good;
            r_err <= w_bad;
            if (w_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_good) begin
                if (r_cmd == CMD_SETLED) begin
                    r_led <= r_data;
                end else if (r_cmd == CMD_CLRALL) begin
                    r_led <= 8'h00;
                    for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'h00;
                end else begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (r_addr[REG_AW-1:0] == REG_AW'(k)) r_regs[k] <= r_data;
                    end
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
            assign regs_o[8*k +: 8] = r_regs[k];
        end
    endgenerate

    assign oe_o        = r_oe;
    assign rd_o        = r_rd;
    assign led_o       = r_led;
    assign frame_ok_o  = r_ok;
    assign frame_err_o = r_err;
    assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ft2232h_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft2232h_cmd_decoder
// Brief    : FT2232H FIFO emulator driving framed commands; scoreboard checks
//            every frame_ok/frame_err pulse and the RD#/OE# handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_ft2232h_cmd_decoder;
    localparam int c_TO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxf = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        hold = 1'b0;
    logic        oe, rd, ok, err;
    logic [7:0]  led, ec;
    logic [31:0] regs;

    ft2232h_cmd_decoder #(
        .NUM_REGS(4), .REG_AW(2), .TIMEOUT_CYC(c_TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .rxf_i(rxf), .data_i(data), .hold_i(hold),
        .oe_o(oe), .rd_o(rd), .led_o(led), .regs_o(regs),
        .frame_ok_o(ok), .frame_err_o(err), .err_cnt_o(ec)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  led;
        logic [31:0] regs;
        logic [7:0]  ec;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fifo[$];
    int         total = 0, bad = 0, cyc = 0;
    int         force_hi = 0, last_pop_cyc = 0, last_pulse_cyc = 0;
    bit         take_pending = 0, hold_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    // One clock of the FIFO emulator: retire the byte the DUT took, then drive.
    task automatic tick();
        @(negedge clk);
        if (take_pending && fifo.size() > 0) begin
            void'(fifo.pop_front());
            last_pop_cyc = cyc;
        end
        if (force_hi > 0) begin
            rxf = 1'b1;
            force_hi--;
        end else begin
            rxf = (fifo.size() == 0);
        end
        if (fifo.size() > 0) data = fifo[0];
        else                 data = 8'h00;
        hold = hold_req;
        take_pending = !rd && !rxf;
    endtask

    task automatic push5(input logic [7:0] a, b, c, d, e);
        fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
        fifo.push_back(d); fifo.push_back(e);
    endtask

    task automatic expect_ev(input bit is_err, input logic [7:0] l,
                             input logic [31:0] r, input logic [7:0] cnt);
        exp_t x;
        x.is_err = is_err; x.led = l; x.regs = r; x.ec = cnt;
        sb.push_back(x);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo.size() > 0 || take_pending) && n < budget) begin tick(); n++; end
        chk("fifo_drained", 64'(fifo.size()), 64'd0);
        n = 0;
        while (sb.size() > 0 && n < budget) begin tick(); n++; end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        tick(); tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_oe", 64'(oe), 64'd1);
        chk("rst_rd", 64'(rd), 64'd1);
        chk("rst_led", 64'(led), 64'd0);
        chk("rst_regs", 64'(regs), 64'd0);
        chk("rst_ok", 64'(ok), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_errcnt", 64'(ec), 64'd0);
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: pops one expectation per pulse and checks the handshake.
    initial begin
        exp_t e;
        logic p_rd = 1'b1, p_oe = 1'b1, pp_oe = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n) begin
                if (ok || err) begin
                    last_pulse_cyc = cyc;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse: got ok=%0b err=%0b want no pulse", ok, err);
                    end else begin
                        e = sb.pop_front();
                        if ({ok, err, led, regs, ec} !== {!e.is_err, e.is_err, e.led, e.regs, e.ec}) begin
                            bad++;
                            $display("FAIL frame_result: got ok=%0b err=%0b led=%h regs=%h ec=%0d want ok=%0b err=%0b led=%h regs=%h ec=%0d",
                                     ok, err, led, regs, ec, !e.is_err, e.is_err, e.led, e.regs, e.ec);
                        end
                    end
                end
                if (!p_rd && (rxf || hold)) begin
                    chk("read_exit_rd_oe", {62'd0, rd, oe}, 64'd3);
                end
                if (!rd && p_rd) begin
                    chk("oe_turnaround", {62'd0, pp_oe, p_oe}, 64'd2);
                end
            end
            pp_oe = p_oe;
            p_oe  = oe;
            p_rd  = rd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        // Basic LED write
        push5(8'hAA, 8'h01, 8'h00, 8'h5A, 8'h5B);
        expect_ev(0, 8'h5A, 32'h0, 8'd0);
        drain(200);

        // Register write, then out-of-range address
        push5(8'hAA, 8'h02, 8'h03, 8'hC3, 8'hC2);
        expect_ev(0, 8'h5A, 32'hC300_0000, 8'd0);
        push5(8'hAA, 8'h02, 8'h04, 8'h11, 8'h17);
        expect_ev(1, 8'h5A, 32'hC300_0000, 8'd1);
        drain(200);

        // Junk, bad checksum, unknown command, clear-all
        fifo.push_back(8'h00); fifo.push_back(8'hFF);
        push5(8'hAA, 8'h01, 8'h00, 8'h33, 8'h30);
        expect_ev(1, 8'h5A, 32'hC300_0000, 8'd2);
        push5(8'hAA, 8'h07, 8'h00, 8'h00, 8'h07);
        expect_ev(1, 8'h5A, 32'hC300_0000, 8'd3);
        push5(8'hAA, 8'h03, 8'h00, 8'h00, 8'h03);
        expect_ev(0, 8'h00, 32'h0, 8'd3);
        drain(200);

        // RXF# gap and hold mid-frame
        push5(8'hAA, 8'h02, 8'h01, 8'h99, 8'h9A);
        expect_ev(0, 8'h00, 32'h0000_9900, 8'd3);
        n = 0;
        while (fifo.size() > 3 && n < 50) begin tick(); n++; end
        force_hi = 3;
        while (fifo.size() > 2 && n < 100) begin tick(); n++; end
        hold_req = 1'b1;
        tick(); tick();
        hold_req = 1'b0;
        drain(200);

        // Timeout mid-frame, then a normal frame
        fifo.push_back(8'hAA); fifo.push_back(8'h01);
        expect_ev(1, 8'h00, 32'h0000_9900, 8'd4);
        drain(200);
        chk("timeout_latency", 64'(last_pulse_cyc - last_pop_cyc), 64'(c_TO));
        push5(8'hAA, 8'h01, 8'h00, 8'hA5, 8'hA4);
        expect_ev(0, 8'hA5, 32'h0000_9900, 8'd4);
        drain(200);

        // Reset mid-frame discards the partial frame
        fifo.push_back(8'hAA); fifo.push_back(8'h02); fifo.push_back(8'h01);
        drain(50);
        do_reset();
        fifo.push_back(8'h01); fifo.push_back(8'h7E); fifo.push_back(8'h7F);
        drain(50);
        for (int i = 0; i < 20; i++) tick();
        push5(8'hAA, 8'h01, 8'h00, 8'h7E, 8'h7F);
        expect_ev(0, 8'h7E, 32'h0, 8'd0);
        drain(200);

        // Back-to-back rejected frames saturate the error counter
        for (int i = 0; i < 260; i++) begin
            push5(8'hAA, 8'h09, 8'h00, 8'h00, 8'h09);
            expect_ev(1, 8'h7E, 32'h0, (i < 255) ? 8'(i + 1) : 8'd255);
        end
        drain(4000);
        chk("errcnt_saturated", 64'(ec), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
